// File: rtl/mem_responder.sv
// Memory-bus responder: pipelined address/data phases, configurable wait states, word array.
// Optional MEM_RESP_ERR_EN adds ERROR responses for out-of-range or misaligned transfers.
`timescale 1ns/1ps
module mem_responder #(
   parameter int                DWidth     = 32,
   parameter int                Depth      = 1024,
   parameter int                WaitStates = 1,
   parameter logic [DWidth-1:0] BaseAddr   = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DWidth-1:0] mem_addr_i,
   input  logic [1:0]        mem_trans_i,
   input  logic              mem_write_i,
   input  logic [DWidth-1:0] mem_wdata_i,
   output logic              mem_ready_o,
   output logic [DWidth-1:0] mem_rdata_o,
   output logic              mem_resp_o
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = (WaitStates > 1) ? $clog2(WaitStates) : 1;
   localparam logic [CW-1:0] WS_LOAD = (WaitStates > 0) ? CW'(WaitStates - 1) : '0;

`ifdef MEM_RESP_ERR_EN
   typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_t;
`else
   typedef enum logic [1:0] {StIdle, StWait, StData} state_t;
`endif

   state_t            r_state, w_nxt, w_start;
   logic [CW-1:0]     r_cnt;
   logic [AW-1:0]     r_idx;
   logic              r_wr;
   logic [DWidth-1:0] r_mem [Depth];

   logic [DWidth-1:0] w_offs, w_word;
   logic [AW-1:0]     w_idx;
   logic              w_ready, w_resp, w_accept, w_err;
   logic              w_unused_ok;

   assign w_offs      = mem_addr_i - BaseAddr;
   assign w_word      = w_offs >> 2;
   assign w_idx       = w_word[AW-1:0];
   assign w_unused_ok = ^w_offs;

`ifdef MEM_RESP_ERR_EN
   assign w_err   = (w_word >= DWidth'(Depth)) || (mem_addr_i < BaseAddr) || (mem_addr_i[1:0] != 2'b00);
   assign w_ready = (r_state != StWait) && (r_state != StErr1);
   assign w_resp  = (r_state == StErr1) || (r_state == StErr2);
`else
   assign w_err   = 1'b0;
   assign w_ready = (r_state != StWait);
   assign w_resp  = 1'b0;
`endif

   // Only NONSEQ/SEQ (trans[1]=1) start a transfer, and only while ready is high.
   assign w_accept = w_ready && mem_trans_i[1];

   always_comb begin
      w_start = StData;
      if (WaitStates > 0) w_start = StWait;
`ifdef MEM_RESP_ERR_EN
      if (w_err) w_start = StErr1;
`endif
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         StWait: if (r_cnt == '0) w_nxt = StData;
`ifdef MEM_RESP_ERR_EN
         StErr1: w_nxt = StErr2;
`endif
         default: w_nxt = w_accept ? w_start : StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_wr    <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_accept) begin
            r_idx <= w_idx;
            r_wr  <= mem_write_i;
            r_cnt <= WS_LOAD;
         end else if (r_state == StWait && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // Array is deliberately not reset; a reset mid-transfer leaves StData unreached.
   always_ff @(posedge clk_i) begin
      if (r_state == StData && r_wr) r_mem[r_idx] <= mem_wdata_i;
   end

   assign mem_ready_o = w_ready;
   assign mem_resp_o  = w_resp;
   assign mem_rdata_o = (r_state == StData && !r_wr) ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WaitStates 0/1/3) against a word-array reference model.
`timescale 1ns/1ps
module tb_mem_responder;
   localparam int DEPTH = 64;
   localparam int NDUT  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  trans [NDUT];
   logic [31:0] addr  [NDUT];
   logic [31:0] wdata [NDUT];
   logic [31:0] rdata [NDUT];
   logic        write [NDUT];
   logic        rdy   [NDUT];
   logic        resp  [NDUT];

   logic [31:0] model [NDUT][DEPTH];
   bit          valid [NDUT][DEPTH];
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mem_responder #(
         .DWidth(32), .Depth(DEPTH),
         .WaitStates((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
         .BaseAddr(32'h0)
      ) u_dut (
         .clk_i(clk), .rst_i(rst),
         .mem_addr_i(addr[g]), .mem_trans_i(trans[g]), .mem_write_i(write[g]),
         .mem_wdata_i(wdata[g]), .mem_ready_o(rdy[g]), .mem_rdata_o(rdata[g]),
         .mem_resp_o(resp[g])
      );
   end

   function automatic int ws_of(int d);
      return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
   endfunction

   function automatic int idx_of(logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Single non-pipelined transfer; junk address phases are driven while ready is low.
   task automatic xfer(int d, bit wr, logic [31:0] a, logic [31:0] wd);
      int waits = 0;
      int ix = idx_of(a);
      logic [31:0] exp_rd = wr ? 32'h0 : model[d][ix];
      trans[d] = 2'b10; addr[d] = a; write[d] = wr; wdata[d] = wd;
      @(posedge clk); #1;
      while (rdy[d] === 1'b0 && waits < 20) begin
         waits++;
         trans[d] = 2'b10; addr[d] = $urandom; write[d] = 1'($urandom);
         @(posedge clk); #1;
      end
      trans[d] = 2'b00;
      chk($sformatf("waits d%0d a%h", d, a), waits, ws_of(d));
      chk($sformatf("resp d%0d a%h", d, a), resp[d], 0);
      chk($sformatf("rdata d%0d a%h", d, a), rdata[d], exp_rd);
      @(posedge clk); #1;
      if (wr) begin
         model[d][ix] = wd;
         valid[d][ix] = 1'b1;
      end
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         trans[d] = 2'b00; addr[d] = '0; write[d] = 1'b0; wdata[d] = '0;
      end
      repeat (2) @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("rst_ready d%0d", d), rdy[d], 1);
         chk($sformatf("rst_resp d%0d", d), resp[d], 0);
         chk($sformatf("rst_rdata d%0d", d), rdata[d], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // WaitStates=1 basic write/read
      xfer(1, 1'b1, 32'h10, 32'hDEADBEEF);
      xfer(1, 1'b0, 32'h10, 32'h0);

      // WaitStates=0 back-to-back write then read of the same word
      trans[0] = 2'b10; addr[0] = 32'h20; write[0] = 1'b1;
      @(posedge clk); #1;
      chk("b2b_wr_ready", rdy[0], 1);
      wdata[0] = 32'h1234; trans[0] = 2'b10; addr[0] = 32'h20; write[0] = 1'b0;
      @(posedge clk); #1;
      chk("b2b_rd_ready", rdy[0], 1);
      chk("b2b_rd_data", rdata[0], 32'h1234);
      trans[0] = 2'b00;
      @(posedge clk); #1;
      model[0][8] = 32'h1234; valid[0][8] = 1'b1;

      // WaitStates=3 with address changes during waits
      xfer(2, 1'b1, 32'h40, 32'hCAFEF00D);
      xfer(2, 1'b0, 32'h40, 32'h0);

      // IDLE/BUSY never start a transfer
      for (int i = 0; i < 5; i++) begin
         trans[1] = 2'($urandom_range(0, 1)); addr[1] = 32'h10; write[1] = 1'b1; wdata[1] = $urandom;
         @(posedge clk); #1;
         chk("idle_ready", rdy[1], 1);
         chk("idle_resp", resp[1], 0);
      end
      trans[1] = 2'b00;
      xfer(1, 1'b0, 32'h10, 32'h0);

      // Reset during the wait state of a write drops it
      xfer(1, 1'b1, 32'h30, 32'h1111);
      trans[1] = 2'b10; addr[1] = 32'h30; write[1] = 1'b1; wdata[1] = 32'h5555;
      @(posedge clk); #1;
      chk("pre_rst_ready", rdy[1], 0);
      trans[1] = 2'b00;
      rst = 1'b1; #1;
      chk("async_rst_ready", rdy[1], 1);
      chk("async_rst_resp", resp[1], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      xfer(1, 1'b0, 32'h30, 32'h0);

      // Out-of-range write: ERROR with the feature, wraps to word 0 without
      xfer(1, 1'b1, 32'h0, 32'hA5A5A5A5);
`ifdef MEM_RESP_ERR_EN
      trans[1] = 2'b10; addr[1] = 32'(4 * DEPTH); write[1] = 1'b1; wdata[1] = 32'hBAD0BAD0;
      @(posedge clk); #1;
      trans[1] = 2'b00;
      chk("err1_ready", rdy[1], 0);
      chk("err1_resp", resp[1], 1);
      @(posedge clk); #1;
      chk("err2_ready", rdy[1], 1);
      chk("err2_resp", resp[1], 1);
      chk("err2_rdata", rdata[1], 0);
      @(posedge clk); #1;
`else
      xfer(1, 1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0);
`endif
      xfer(1, 1'b0, 32'h0, 32'h0);

      // Randomized traffic on every instance
      for (int d = 0; d < NDUT; d++) begin
         for (int i = 0; i < 40; i++) begin
            int  ix = $urandom_range(0, DEPTH - 1);
            bit  wr = ($urandom_range(0, 1) == 1) || !valid[d][ix];
            xfer(d, wr, 32'(ix) << 2, $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
